// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: iterative double-dabble binary-to-BCD converter.
// Each accepted request takes BIN_WIDTH shift/adjust steps and one result
// cycle. The result registers hold their value between conversions, so a
// multiplexed display fed from bcd_o does not flicker while a conversion runs.
// Optional build macro: BCD_SATURATE_EN. When it is defined, values above 9999
// show 16'h9999. When it is not defined, they show value mod 10000.
// ovf_o flags values above 9999 in both builds.

module bin_to_bcd_seq #(
    parameter int BIN_WIDTH = 14
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 valid_i,
    input  logic [BIN_WIDTH-1:0] bin_i,
    output logic                 ready_o,
    output logic                 valid_o,
    output logic [15:0]          bcd_o,
    output logic                 ovf_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                   state_r;
    state_t                   state_s;
    logic [BIN_WIDTH-1:0]     shift_r;
    logic [19:0]              acc_r;
    logic [4:0]               cnt_r;
    logic                     ovf_r;
    logic [19:0]              adj_s;
    logic [BIN_WIDTH+19:0]    step_s;
    logic [16:0]              bin_ext_s;
    logic                     over_s;

    // Add 3 to every BCD digit that is 5 or more, before the shift.
    function automatic logic [19:0] add3_digits(input logic [19:0] acc);
        logic [19:0] res;
        res = acc;
        for (int d = 0; d < 5; d++) begin
            if (acc[d*4 +: 4] >= 4'd5) begin
                res[d*4 +: 4] = acc[d*4 +: 4] + 4'd3;
            end else begin
                res[d*4 +: 4] = acc[d*4 +: 4];
            end
        end
        return res;
    endfunction

    // One double-dabble step, and the range test on the incoming value.
    always_comb begin
        adj_s     = add3_digits(acc_r);
        step_s    = {adj_s, shift_r} << 1;
        bin_ext_s = {{(17-BIN_WIDTH){1'b0}}, bin_i};
        over_s    = (bin_ext_s > 17'd9999);
    end

    // State register.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic. A request made outside IDLE is dropped.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (valid_i) begin
                    state_s = SHIFT;
                end else begin
                    state_s = IDLE;
                end
            end
            SHIFT: begin
                if (cnt_r == 5'd0) begin
                    state_s = DONE;
                end else begin
                    state_s = SHIFT;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Working registers: load on accept, then shift and adjust once per step.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            shift_r <= '0;
            acc_r   <= 20'h00000;
            cnt_r   <= 5'd0;
            ovf_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (valid_i) begin
                        shift_r <= bin_i;
                        acc_r   <= 20'h00000;
                        cnt_r   <= 5'(BIN_WIDTH - 1);
                        ovf_r   <= over_s;
                    end
                end
                SHIFT: begin
                    acc_r   <= step_s[BIN_WIDTH+19:BIN_WIDTH];
                    shift_r <= step_s[BIN_WIDTH-1:0];
                    if (cnt_r != 5'd0) begin
                        cnt_r <= cnt_r - 5'd1;
                    end
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

    // Result registers: update and pulse valid_o only on the DONE cycle.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            valid_o <= 1'b0;
            bcd_o   <= 16'h0000;
            ovf_o   <= 1'b0;
        end else begin
            valid_o <= (state_r == DONE);
            if (state_r == DONE) begin
`ifdef BCD_SATURATE_EN
                bcd_o <= ovf_r ? 16'h9999 : acc_r[15:0];
`else
                bcd_o <= acc_r[15:0];
`endif
                ovf_o <= ovf_r;
            end
        end
    end

    // ready_o is decoded straight from the state register.
    assign ready_o = (state_r == IDLE);

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed, table-driven bench for bin_to_bcd_seq at the default BIN_WIDTH.
module tb_bin_to_bcd_seq;

    localparam int BW = 14;

    logic          clk_i = 1'b0;
    logic          reset_i;
    logic          valid_i;
    logic [BW-1:0] bin_i;
    logic          ready_o;
    logic          valid_o;
    logic [15:0]   bcd_o;
    logic          ovf_o;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [15:0] bin;
        logic [15:0] bcd;
        logic        ovf;
    } vec_t;

    vec_t vecs[9];

    bin_to_bcd_seq #(.BIN_WIDTH(BW)) dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .valid_i (valid_i),
        .bin_i   (bin_i),
        .ready_o (ready_o),
        .valid_o (valid_o),
        .bcd_o   (bcd_o),
        .ovf_o   (ovf_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // Waits up to 40 edges for valid_o; lat is the edge count, -1 on timeout.
    task automatic wait_valid(output int lat);
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk_i);
            @(negedge clk_i);
            if (valid_o) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic convert(input logic [15:0] bin, input logic [15:0] eb,
                           input logic eo, input string name);
        int lat;
        @(negedge clk_i);
        check({name, " ready_before"}, ready_o, 1);
        bin_i   = bin[BW-1:0];
        valid_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        valid_i = 1'b0;
        bin_i   = '0;
        check({name, " busy"}, ready_o, 0);
        wait_valid(lat);
        check({name, " latency"}, lat, BW + 1);
        check({name, " bcd"}, bcd_o, eb);
        check({name, " ovf"}, ovf_o, eo);
        check({name, " ready_with_valid"}, ready_o, 1);
        @(posedge clk_i);
        @(negedge clk_i);
        check({name, " pulse_one_cycle"}, valid_o, 0);
        check({name, " bcd_hold"}, bcd_o, eb);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int pulses;
        logic [15:0] seq_bin[4];
        logic [15:0] seq_exp[4];
        logic [15:0] first_bcd;

        vecs[0] = '{16'd1234,  16'h1234, 1'b0};
        vecs[1] = '{16'd0,     16'h0000, 1'b0};
        vecs[2] = '{16'd9,     16'h0009, 1'b0};
        vecs[3] = '{16'd10,    16'h0010, 1'b0};
        vecs[4] = '{16'd9999,  16'h9999, 1'b0};
        vecs[5] = '{16'd5678,  16'h5678, 1'b0};
        vecs[6] = '{16'd8091,  16'h8091, 1'b0};
`ifdef BCD_SATURATE_EN
        vecs[7] = '{16'd10000, 16'h9999, 1'b1};
        vecs[8] = '{16'd16383, 16'h9999, 1'b1};
`else
        vecs[7] = '{16'd10000, 16'h0000, 1'b1};
        vecs[8] = '{16'd16383, 16'h6383, 1'b1};
`endif
        seq_bin = '{16'd0, 16'd9, 16'd10, 16'd9999};
        seq_exp = '{16'h0000, 16'h0009, 16'h0010, 16'h9999};

        reset_i = 1'b1;
        valid_i = 1'b0;
        bin_i   = '0;
        repeat (2) @(negedge clk_i);
        check("reset ready", ready_o, 1);
        check("reset valid", valid_o, 0);
        check("reset bcd", bcd_o, 16'h0000);
        check("reset ovf", ovf_o, 0);
        reset_i = 1'b0;

        for (int v = 0; v < 9; v++) begin
            convert(vecs[v].bin, vecs[v].bcd, vecs[v].ovf, $sformatf("vec%0d", v));
        end

        // Back-to-back requests with valid_i held high.
        @(negedge clk_i);
        bin_i   = seq_bin[0][BW-1:0];
        valid_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_valid(lat);
            check($sformatf("b2b%0d arrived", k), (lat == -1) ? 0 : 1, 1);
            check($sformatf("b2b%0d bcd", k), bcd_o, seq_exp[k]);
            check($sformatf("b2b%0d ovf", k), ovf_o, 0);
            if (k < 3) begin
                bin_i = seq_bin[k+1][BW-1:0];
            end else begin
                valid_i = 1'b0;
            end
        end
        repeat (2) @(negedge clk_i);

        // Request made while busy must be dropped.
        bin_i   = 14'd4321;
        valid_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        valid_i = 1'b0;
        repeat (4) @(posedge clk_i);
        @(negedge clk_i);
        bin_i   = 14'd5555;
        valid_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        valid_i   = 1'b0;
        pulses    = 0;
        first_bcd = 16'hFFFF;
        for (int i = 0; i < 45; i++) begin
            @(posedge clk_i);
            @(negedge clk_i);
            if (valid_o) begin
                if (pulses == 0) first_bcd = bcd_o;
                pulses++;
            end
        end
        check("drop pulses", pulses, 1);
        check("drop bcd", first_bcd, 16'h4321);
        check("drop bcd_hold", bcd_o, 16'h4321);

        // Asynchronous reset in the middle of a conversion.
        bin_i   = 14'd8765;
        valid_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        valid_i = 1'b0;
        repeat (7) @(posedge clk_i);
        #3;
        reset_i = 1'b1;
        #1;
        check("abort bcd", bcd_o, 16'h0000);
        check("abort valid", valid_o, 0);
        check("abort ready", ready_o, 1);
        @(negedge clk_i);
        reset_i = 1'b0;
        pulses  = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk_i);
            @(negedge clk_i);
            if (valid_o) pulses++;
        end
        check("abort no_pulse", pulses, 0);
        check("abort bcd_after", bcd_o, 16'h0000);
        convert(16'd42, 16'h0042, 1'b0, "after_abort");

        // Result holds through a long idle stretch.
        convert(16'd1111, 16'h1111, 1'b0, "idle_start");
        pulses = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk_i);
            @(negedge clk_i);
            if (valid_o) pulses++;
        end
        check("idle no_pulse", pulses, 0);
        check("idle bcd", bcd_o, 16'h1111);
        check("idle ready", ready_o, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
